// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: turns step commands into Gray-coded A/B phases with a minimum dwell.
// Optional index output z is enabled by defining QUAD_INDEX_EN.
module quad_encoder_gen #(
  parameter int DWELL_W = 16,
  parameter int POS_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_valid,
  input  logic               step_dir,
  output logic               step_ready,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               pos_clr,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic [POS_W-1:0]   position,
  output logic               z
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DWELL_W-1:0] cnt;
  logic [POS_W-1:0]   pos_nxt;
  logic               accept;

  assign accept = step_valid && step_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = HOLD;
      HOLD:    if (!accept && cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step_ready = (state == IDLE) || (state == HOLD && cnt == '0);
    busy       = (state == HOLD);
  end

  // Dwell counter holds the remaining cycles before the next step may be taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    end else if (state == HOLD && cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  // Forward rotates 00->10->11->01; reverse runs the same ring backwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a <= 1'b0;
      b <= 1'b0;
    end else if (accept) begin
      if (step_dir) begin
        a <= ~b;
        b <= a;
      end else begin
        a <= b;
        b <= ~a;
      end
    end
  end

  // Clear has priority over a coincident step for the position only.
  always_comb begin
    pos_nxt = position;
    if (pos_clr)     pos_nxt = '0;
    else if (accept) pos_nxt = step_dir ? position + POS_W'(1) : position - POS_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) position <= '0;
    else        position <= pos_nxt;
  end

`ifdef QUAD_INDEX_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) z <= 1'b1;
    else        z <= (pos_nxt == '0);
  end
`else
  assign z = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: directed scenarios plus randomized traffic
// compared against a phase-index / cycle-arithmetic reference model.
module tb_quad_encoder_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step_valid = 1'b0;
  logic        step_dir = 1'b0;
  logic        step_ready;
  logic [15:0] dwell = '0;
  logic        pos_clr = 1'b0;
  logic        a, b, busy, z;
  logic [15:0] position;

`ifdef QUAD_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  quad_encoder_gen #(.DWELL_W(16), .POS_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .dwell      (dwell),
    .pos_clr    (pos_clr),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .position   (position),
    .z          (z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase index on the ring, wrapped position, accept timing by cycle arithmetic.
  logic [1:0]  ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int          m_idx;
  logic [15:0] m_pos;
  longint      m_cyc;
  longint      m_last;
  int          m_deff;
  bit          m_accepted;

  function automatic bit model_ready();
    return (m_last < 0) || (m_cyc + 1 - m_last >= m_deff);
  endfunction

  function automatic bit model_busy();
    return (m_last >= 0) && (m_cyc - m_last < m_deff);
  endfunction

  function automatic int ab_index(input logic [1:0] v);
    for (int i = 0; i < 4; i++) if (ab_tab[i] == v) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_pos = '0; m_cyc = 0; m_last = -1; m_deff = 1; m_accepted = 1'b0;
  endtask

  // Loopback decoder: counts +1 for a forward ring move, -1 for a reverse one.
  int         dec_count = 0;
  logic [1:0] dec_prev = 2'b00;
  always @(negedge clk) begin
    if (reset) begin
      case ((ab_index({a, b}) - ab_index(dec_prev)) & 3)
        1: dec_count++;
        3: dec_count--;
        default: ;
      endcase
    end
    dec_prev = {a, b};
  end

  task automatic tick(input bit v, input bit d, input int dw, input bit clr);
    step_valid = v; step_dir = d; dwell = dw[15:0]; pos_clr = clr;
    m_accepted = v && model_ready();
    @(posedge clk);
    m_cyc++;
    if (m_accepted) begin
      m_idx  = d ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
      m_pos  = d ? m_pos + 16'd1 : m_pos - 16'd1;
      m_last = m_cyc;
      m_deff = (dw == 0) ? 1 : dw;
    end
    if (clr) m_pos = '0;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0; step_valid = 1'b0; pos_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({a, b, busy, step_ready, z} !== {1'b0, 1'b0, 1'b0, 1'b1, IDX_EN}) begin
      n_fail++;
      $display("FAIL reset_flags: got a,b,busy,ready,z=%b expected %b",
               {a, b, busy, step_ready, z}, {1'b0, 1'b0, 1'b0, 1'b1, IDX_EN});
    end
    n_checks++;
    if (position !== 16'h0000) begin
      n_fail++; $display("FAIL reset_position: got %h expected 0000", position);
    end
  endtask

  task automatic test_forward_dwell3();
    logic [1:0] exp_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    longint acc_cyc [$];
    apply_reset();
    for (int c = 0; c < 40 && acc_cyc.size() < 4; c++) begin
      tick(1, 1, 3, 0);
      if (m_accepted) begin
        n_checks++;
        if ({a, b} !== exp_ab[acc_cyc.size()]) begin
          n_fail++;
          $display("FAIL fwd3_ab[%0d]: got %b expected %b", acc_cyc.size(), {a, b}, exp_ab[acc_cyc.size()]);
        end
        acc_cyc.push_back(m_cyc);
      end
    end
    n_checks++;
    if (acc_cyc.size() != 4) begin
      n_fail++; $display("FAIL fwd3_accepts: got %0d expected 4", acc_cyc.size());
    end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      n_checks++;
      if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
        n_fail++; $display("FAIL fwd3_spacing[%0d]: got %0d expected 3", k, acc_cyc[k] - acc_cyc[k-1]);
      end
    end
    n_checks++;
    if (position !== 16'd4) begin
      n_fail++; $display("FAIL fwd3_position: got %0d expected 4", position);
    end
    for (int c = 0; c < 8 && busy; c++) tick(0, 1, 3, 0);
    n_checks++;
    if (busy !== 1'b0 || m_cyc - m_last != 3) begin
      n_fail++; $display("FAIL fwd3_busy_drop: got busy=%b after %0d cycles expected 0 after 3", busy, m_cyc - m_last);
    end
  endtask

  task automatic test_reverse_dwell5();
    int low = 0;
    apply_reset();
    tick(1, 0, 5, 0);
    n_checks++;
    if ({a, b} !== 2'b01 || position !== 16'hFFFF) begin
      n_fail++; $display("FAIL rev5_step: got ab=%b pos=%h expected ab=01 pos=ffff", {a, b}, position);
    end
    for (int c = 0; c < 10 && !step_ready; c++) begin
      low++;
      tick(0, 0, 5, 0);
    end
    n_checks++;
    if (low != 4 || step_ready !== 1'b1) begin
      n_fail++; $display("FAIL rev5_ready_low: got %0d cycles ready=%b expected 4 cycles then 1", low, step_ready);
    end
  endtask

  task automatic test_dwell0();
    logic [1:0] prev;
    apply_reset();
    dec_count = 0;
    for (int k = 0; k < 8; k++) begin
      prev = {a, b};
      tick(1, 1, 0, 0);
      n_checks++;
      if ($countones(prev ^ {a, b}) != 1) begin
        n_fail++; $display("FAIL dwell0_change[%0d]: got %b->%b expected one bit change", k, prev, {a, b});
      end
    end
    tick(0, 1, 0, 0);
    n_checks++;
    if (position !== 16'd8 || dec_count != 8) begin
      n_fail++; $display("FAIL dwell0_count: got pos=%0d decoder=%0d expected 8 and 8", position, dec_count);
    end
  endtask

  task automatic test_reversal_and_clear();
    bit         dirs [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp_ab [3] = '{2'b10, 2'b11, 2'b10};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      m_accepted = 1'b0;
      for (int c = 0; c < 10 && !m_accepted; c++) tick(1, dirs[k], 2, 0);
      n_checks++;
      if (!m_accepted || {a, b} !== exp_ab[k]) begin
        n_fail++; $display("FAIL rev_ab[%0d]: got %b expected %b", k, {a, b}, exp_ab[k]);
      end
    end
    n_checks++;
    if (position !== 16'd1) begin
      n_fail++; $display("FAIL rev_position: got %0d expected 1", position);
    end
    for (int c = 0; c < 10 && !step_ready; c++) tick(0, 1, 2, 0);
    tick(1, 1, 2, 1);
    n_checks++;
    if (position !== 16'd0 || {a, b} !== 2'b11 || z !== IDX_EN) begin
      n_fail++; $display("FAIL clr_with_step: got pos=%0d ab=%b z=%b expected 0 11 %b", position, {a, b}, z, IDX_EN);
    end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    tick(1, 1, 100, 0);
    repeat (10) tick(0, 1, 100, 0);
    n_checks++;
    if (busy !== 1'b1 || {a, b} !== 2'b10) begin
      n_fail++; $display("FAIL midhold_pre: got busy=%b ab=%b expected 1 10", busy, {a, b});
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({a, b, busy, step_ready, z} !== {1'b0, 1'b0, 1'b0, 1'b1, IDX_EN} || position !== 16'd0) begin
      n_fail++; $display("FAIL midhold_async: got a,b,busy,ready,z=%b pos=%0d expected 0001%b pos=0",
                         {a, b, busy, step_ready, z}, position, IDX_EN);
    end
    model_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    tick(1, 1, 1, 0);
    n_checks++;
    if ({a, b} !== 2'b10 || position !== 16'd1 || z !== 1'b0) begin
      n_fail++; $display("FAIL midhold_first_step: got ab=%b pos=%0d z=%b expected 10 1 0", {a, b}, position, z);
    end
    tick(1, 0, 1, 0);
    n_checks++;
    if ({a, b} !== 2'b00 || position !== 16'd0 || z !== IDX_EN) begin
      n_fail++; $display("FAIL index_back_to_zero: got ab=%b pos=%0d z=%b expected 00 0 %b", {a, b}, position, z, IDX_EN);
    end
  endtask

  task automatic test_random();
    bit v, d, clr;
    int dw;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      d   = $urandom_range(0, 1);
      dw  = $urandom_range(0, 4);
      clr = ($urandom_range(0, 40) == 0);
      n_checks++;
      if (step_ready !== model_ready()) begin
        n_fail++; $display("FAIL rand_ready@%0d: got %b expected %b", c, step_ready, model_ready());
      end
      tick(v, d, dw, clr);
      n_checks++;
      if ({a, b} !== ab_tab[m_idx] || position !== m_pos || busy !== model_busy()
          || z !== (IDX_EN && m_pos == 16'd0)) begin
        n_fail++;
        $display("FAIL rand_state@%0d: got ab=%b pos=%h busy=%b z=%b expected ab=%b pos=%h busy=%b z=%b",
                 c, {a, b}, position, busy, z, ab_tab[m_idx], m_pos, model_busy(), IDX_EN && m_pos == 16'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_forward_dwell3();
    test_reverse_dwell5();
    test_dwell0();
    test_reversal_and_clear();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
# quad_encoder_gen

Quadrature encoder generator: converts a stream of single-step commands (direction + handshake) into Gray-coded A/B channel waveforms with a programmable minimum phase dwell, and tracks the emitted position. It drives the A/B inputs of the FPGA's quadrature decoder on the bench or loopback path, and can stand in for the physical encoder during bring-up. Forward steps must be counted up by the decoder (A leads B).

## Interface
- DWELL_W, 16, width of dwell input and dwell counter
- POS_W, 16, width of position counter
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- step_valid  in  1  step request present
- step_dir  in  1  1 = forward, 0 = reverse; qualified by step_valid
- step_ready  out  1  block can accept a step this cycle
- dwell  in  DWELL_W  minimum cycles between A/B transitions; sampled on accept
- pos_clr  in  1  synchronous clear of position
- a  out  1  channel A, registered
- b  out  1  channel B, registered
- busy  out  1  high while a dwell is in progress
- position  out  POS_W  signed-wrap step count, registered
- z  out  1  index output (see Configuration)

## Operation
- Phase sequence {a,b}, forward: 00 → 10 → 11 → 01 → 00. Reverse traverses the same cycle backwards. Exactly one of a/b changes per step.
- States: IDLE, HOLD. dwell_eff = max(dwell, 1).
- Accept = step_valid && step_ready, sampled on a clk edge.
- step_ready = (state == IDLE) || (state == HOLD && cnt == 0). It is combinational from state and cnt only, never from step_valid.
- On accept: phase advances one step per step_dir. cnt is loaded with dwell_eff−1. State goes to (or stays in) HOLD. position ±1 modulo 2^POS_W.
- HOLD, no accept: if cnt > 0, decrement; if cnt == 0, go to IDLE.
- busy = (state == HOLD).
- dwell is captured only at accept; changes during HOLD are ignored until the next accept.
- Direction reversal between consecutive steps is legal. Phase steps back one position; no extra dwell is added.
- pos_clr: position becomes 0 on that edge. If it coincides with an accepted step, the clear wins for position (result 0), and the phase still advances.
- Position wraps: 2^POS_W−1 + forward → 0; 0 + reverse → 2^POS_W−1.

## Timing
- Reset values: a=0, b=0, position=0, busy=0, step_ready=1, state IDLE, cnt=0. z=1 with the macro, 0 without.
- Reset asserted mid-HOLD: state is abandoned immediately, and outputs return to reset values asynchronously.
- Latency: a/b/position update on the same edge that accepts the step (one edge after step_valid is presented with ready high).
- With step_valid held high continuously, A/B transitions occur exactly every dwell_eff cycles. dwell=0 or 1 gives one transition per cycle.
- step_valid may be held or dropped freely. Nothing is accepted while step_ready=0, and step_dir is ignored then.

## Configuration
- QUAD_INDEX_EN defined: z is registered, updated on the same edge as position. z = 1 iff the new position == 0, so it is high after reset and after pos_clr.
- QUAD_INDEX_EN undefined: z is tied to 0 and no index logic is synthesized. The port remains present.

## Test plan
- Reset: hold reset low, then release → a=b=0, position=0, step_ready=1, busy=0; z=1 (macro on) or 0 (off).
- dwell=3, 4 forward steps with step_valid held → {a,b} = 10, 11, 01, 00 on accept edges spaced exactly 3 cycles apart. position=4, and busy drops 3 cycles after the last accept.
- From reset, 1 reverse step with dwell=5 → {a,b}=01, position=0xFFFF. step_ready is low for 4 cycles, then high.
- dwell=0, 8 forward steps with valid held → one A/B change per cycle, position=8, and the decoder loopback counts +8.
- Forward, forward, reverse with dwell=2 → {a,b}=10, 11, 10, position=1. Also pos_clr together with a forward step → position=0 and the phase still advances.
- Reset asserted mid-HOLD (dwell=100, after 10 cycles) → a=b=0, position=0 immediately. After release, the first step gives {a,b}=10. With QUAD_INDEX_EN: z goes high after a reset, low after step 1, and high again after a reverse step back to 0.
